// File: rtl/memory_access_pkg.sv
// Shared types and constants for the MEM pipeline stage: funct3 encodings,
// FSM state codes, byte-enable patterns and access-size helpers.
package memory_access_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t ACCESS = 2'd1;
   localparam state_t DONE   = 2'd2;

   localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
   localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
   localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} size_t;

   // Per-request control captured at issue, used for the load extract.
   typedef struct packed {
      logic [2:0] funct3;
      logic [1:0] offset;
   } req_ctrl_t;

   // Unknown encodings fall back to a word access.
   function automatic size_t access_size(input logic [2:0] f3);
      case (f3)
         FUNCT3_LB, FUNCT3_LBU: access_size = SIZE_B;
         FUNCT3_LH, FUNCT3_LHU: access_size = SIZE_H;
         default:               access_size = SIZE_W;
      endcase
   endfunction

   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] offset);
      case (access_size(f3))
         SIZE_B:  is_aligned = 1'b1;
         SIZE_H:  is_aligned = (offset[0] == 1'b0);
         default: is_aligned = (offset == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and memory (slave).
interface memory_access_stage_if #(parameter int unsigned ADDR_WIDTH = 32);

   logic                  memRequest;
   logic                  memWriteEnable;
   logic [ADDR_WIDTH-1:0] memAddress;
   logic [31:0]           memWriteData;
   logic [3:0]            memByteEnable;
   logic                  memReady;
   logic [31:0]           memReadDataIn;

   modport master (
      output memRequest, memWriteEnable, memAddress, memWriteData, memByteEnable,
      input  memReady, memReadDataIn
   );

   modport slave (
      input  memRequest, memWriteEnable, memAddress, memWriteData, memByteEnable,
      output memReady, memReadDataIn
   );

endinterface

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data lane select with sign/zero extension.
module load_store_align
   import memory_access_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [1:0]        offset,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] load_word,
   output logic [BE_W-1:0]   byte_enable_c,
   output logic [DATA_W-1:0] write_data_c,
   output logic [DATA_W-1:0] load_data_c
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   assign lane_byte = 8'(load_word >> {offset, 3'b000});
   assign lane_half = offset[1] ? load_word[31:16] : load_word[15:0];

   // funct3[2] selects the unsigned load variants.
   always_comb begin
      byte_enable_c = BE_WORD;
      write_data_c  = store_data;
      load_data_c   = load_word;
      case (access_size(funct3))
         SIZE_B: begin
            byte_enable_c = BE_BYTE << offset;
            write_data_c  = {4{store_data[7:0]}};
            load_data_c   = funct3[2] ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
         end
         SIZE_H: begin
            byte_enable_c = BE_HALF << offset;
            write_data_c  = {2{store_data[15:0]}};
            load_data_c   = funct3[2] ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
         end
         default: begin
            byte_enable_c = BE_WORD;
            write_data_c  = store_data;
            load_data_c   = load_word;
         end
      endcase
   end

endmodule

// File: rtl/memory_access_stage.sv
// RISC-V MEM stage: issues load/store requests, stalls until memory responds.
// Optional ACCESS timeout with busError pulse under MEMORY_ACCESS_TIMEOUT_EN.
module memory_access_stage
   import memory_access_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
`ifdef MEMORY_ACCESS_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                inValid,
   input  logic                memRead,
   input  logic                memWrite,
   input  logic [2:0]          funct3,
   input  logic [DATA_W-1:0]   aluResult,
   input  logic [DATA_W-1:0]   storeData,
   input  logic                writeBackFromMemoryOrAlu,
   memory_access_stage_if.master mem,
   output logic                stallPipeline,
   output logic                outValid,
   output logic [DATA_W-1:0]   memoryReadData,
   output logic [DATA_W-1:0]   aluData,
   output logic                writeBackFromMemoryOrAluOut,
   output logic                misaligned,
   output logic                busError
);

   state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   req_ctrl_t         ctrl_q;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              capture_req, capture_rdata;

   logic [2:0]        align_funct3;
   logic [1:0]        align_offset;
   logic [BE_W-1:0]   be_c;
   logic [DATA_W-1:0] wdata_c, load_c;

   // Issue uses live inputs; ACCESS uses the captured request for the extract.
   assign align_funct3 = (state_q == ACCESS) ? ctrl_q.funct3 : funct3;
   assign align_offset = (state_q == ACCESS) ? ctrl_q.offset : aluResult[1:0];

   load_store_align u_align (
      .funct3        (align_funct3),
      .offset        (align_offset),
      .store_data    (storeData),
      .load_word     (mem.memReadDataIn),
      .byte_enable_c (be_c),
      .write_data_c  (wdata_c),
      .load_data_c   (load_c)
   );

   assign aluData                     = aluResult;
   assign writeBackFromMemoryOrAluOut = writeBackFromMemoryOrAlu;

   assign mem.memRequest     = (state_q == ACCESS);
   assign mem.memWriteEnable = we_q;
   assign mem.memAddress     = addr_q;
   assign mem.memWriteData   = wdata_q;
   assign mem.memByteEnable  = be_q;

`ifdef MEMORY_ACCESS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             bus_error_q, bus_error_d, timeout_c;

   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem.memReady;
   assign busError  = bus_error_q;
`else
   assign busError = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      stallPipeline  = 1'b0;
      outValid       = 1'b0;
      memoryReadData = '0;
      misaligned     = 1'b0;
      capture_req    = 1'b0;
      capture_rdata  = 1'b0;
      rdata_d        = '0;
`ifdef MEMORY_ACCESS_TIMEOUT_EN
      bus_error_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (inValid) begin
               if (memRead || memWrite) begin
                  if (!is_aligned(funct3, aluResult[1:0])) begin
                     misaligned = 1'b1;
                     outValid   = 1'b1;
                  end else begin
                     stallPipeline = 1'b1;
                     capture_req   = 1'b1;
                     state_d       = ACCESS;
                  end
               end else begin
                  outValid = 1'b1;
               end
            end
         end
         ACCESS: begin
            stallPipeline = 1'b1;
            if (mem.memReady) begin
               capture_rdata = 1'b1;
               rdata_d       = we_q ? '0 : load_c;
               state_d       = DONE;
            end
`ifdef MEMORY_ACCESS_TIMEOUT_EN
            else if (timeout_c) begin
               capture_rdata = 1'b1;
               bus_error_d   = 1'b1;
               state_d       = DONE;
            end
`endif
         end
         DONE: begin
            outValid       = 1'b1;
            memoryReadData = rdata_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request and response capture registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ctrl_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (capture_req) begin
            addr_q  <= ADDR_WIDTH'({aluResult[DATA_W-1:2], 2'b00});
            be_q    <= be_c;
            wdata_q <= wdata_c;
            we_q    <= memWrite;
            ctrl_q  <= '{funct3: funct3, offset: aluResult[1:0]};
         end
         if (capture_rdata) rdata_q <= rdata_d;
      end
   end

`ifdef MEMORY_ACCESS_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         bus_error_q <= 1'b0;
      end else begin
         bus_error_q <= bus_error_d;
         if (capture_req)
            cnt_q <= '0;
         else if (state_q == ACCESS && !mem.memReady)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`endif

endmodule
